uart_tx: RTL and testbench



---
 rtl/uart_tx_if.sv | 30 +++
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_if
// Brief    : Byte handshake between the APB/FIFO front end and the UART
//            transmitter (start/data_in in, busy/done back).
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 start;
  logic [DATA_BITS-1:0] data_in;
  logic                 busy;
  logic                 done;

  modport master (
    output start,
    output data_in,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  data_in,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : UART transmitter; serialises a byte LSB-first as start, data,
//            optional parity and stop bits, paced by a shared baud_tick.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic baud_tick,
  uart_tx_if.slave  bus,
  output logic      tx
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  logic [2:0]           state_q,  state_d;
  logic                 tx_q,     tx_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;
  logic                 parity_q, parity_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    parity_d = parity_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        // Accept needs no tick, so a coincident tick is not the start-bit edge.
        if (bus.start) begin
          shift_d  = bus.data_in;
          parity_d = (^bus.data_in) ^ (PARITY_ODD != 0);
          busy_d   = 1'b1;
          state_d  = S_SYNC;
        end
      end
      S_SYNC: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          tx_d    = shift_q[0];
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (cnt_q != CNT_LAST) begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            cnt_d   = cnt_q + 1'b1;
          end else if (PARITY_EN != 0) begin
            tx_d    = parity_q;
            state_d = S_PARITY;
          end else begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      parity_q <= 1'b0;
      cnt_q    <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      parity_q <= parity_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
    end
  end

  assign tx       = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Random-stimulus bench for three uart_tx variants (no parity,
//            even parity, odd parity) against a frame-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] tx;
  int         tick_div = 0;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx_if #(.DATA_BITS(8)) if2 ();

  assign if0.start = start;  assign if0.data_in = data_in;
  assign if1.start = start;  assign if1.data_in = data_in;
  assign if2.start = start;  assign if2.data_in = data_in;

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(if0), .tx(tx[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(if1), .tx(tx[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(if2), .tx(tx[2]));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick_div  = (tick_div + 1) % 16;
    baud_tick = (tick_div == 0);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each accepted byte becomes a list of line levels that is
  // played out one entry per tick; the tick after the list runs dry ends the frame.
  int          PEN  [3] = '{0, 1, 1};
  int          PODD [3] = '{0, 0, 1};
  logic [11:0] m_frame [3];
  int          m_len   [3];
  int          m_pos   [3];
  bit          m_busy  [3] = '{0, 0, 0};
  bit          m_tx    [3] = '{1, 1, 1};
  bit          m_done  [3] = '{0, 0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_busy[i] = 0; m_tx[i] = 1; m_done[i] = 0;
      end else begin
        m_done[i] = 0;
        if (!m_busy[i]) begin
          if (start) begin
            m_busy[i]     = 1;
            m_frame[i]    = '1;
            m_frame[i][0] = 1'b0;
            for (int b = 0; b < 8; b++) m_frame[i][1+b] = data_in[b];
            if (PEN[i] != 0) m_frame[i][9] = (^data_in) ^ (PODD[i] != 0);
            m_len[i] = 10 + PEN[i];
            m_pos[i] = 0;
          end
        end else if (baud_tick) begin
          if (m_pos[i] < m_len[i]) begin
            m_tx[i] = m_frame[i][m_pos[i]];
            m_pos[i]++;
          end else begin
            m_tx[i] = 1; m_busy[i] = 0; m_done[i] = 1;
          end
        end
      end
    end
    #1;
    check_eq("tx0",   {31'd0, tx[0]},    {31'd0, m_tx[0]});
    check_eq("busy0", {31'd0, if0.busy}, {31'd0, m_busy[0]});
    check_eq("done0", {31'd0, if0.done}, {31'd0, m_done[0]});
    check_eq("tx1",   {31'd0, tx[1]},    {31'd0, m_tx[1]});
    check_eq("busy1", {31'd0, if1.busy}, {31'd0, m_busy[1]});
    check_eq("done1", {31'd0, if1.done}, {31'd0, m_done[1]});
    check_eq("tx2",   {31'd0, tx[2]},    {31'd0, m_tx[2]});
    check_eq("busy2", {31'd0, if2.busy}, {31'd0, m_busy[2]});
    check_eq("done2", {31'd0, if2.done}, {31'd0, m_done[2]});
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  // Pulse start for one clk, aligned either away from or onto a tick clk.
  task automatic drive_start(input logic [7:0] d, input bit on_tick);
    int guard = 0;
    do begin
      step();
      guard++;
    end while ((baud_tick != on_tick) && guard < 64);
    check_eq("tick_align_timeout", guard, (guard < 64) ? guard : 0);
    start   = 1'b1;
    data_in = d;
    step();
    start   = 1'b0;
    data_in = 8'($urandom);
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    int guard = 0;
    while (seen < n && guard < 2000) begin
      step();
      guard++;
      if (baud_tick) seen++;
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    bit timed_out;
    while ((m_busy[0] || m_busy[1] || m_busy[2] ||
            if0.busy || if1.busy || if2.busy) && guard < 1000) begin
      step();
      guard++;
    end
    timed_out = (guard >= 1000);
    check_eq("idle_timeout", {31'd0, timed_out}, 32'd0);
    repeat (2) step();
  endtask

  initial begin
    bit seen_done [3];
    int guard;

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    drive_start(8'hA5, 1'b0);
    wait_idle();

    // Request while busy is dropped; holding it through done starts the next frame.
    drive_start(8'h3C, 1'b0);
    wait_ticks(4);
    start   = 1'b1;
    data_in = 8'hFF;
    seen_done = '{0, 0, 0};
    guard = 0;
    while (!(seen_done[0] && seen_done[1] && seen_done[2] &&
             m_busy[0] && m_busy[1] && m_busy[2]) && guard < 1000) begin
      step();
      guard++;
      for (int i = 0; i < 3; i++) if (m_done[i]) seen_done[i] = 1;
    end
    start = 1'b0;
    wait_idle();

    // Reset during data bit 4.
    drive_start(8'($urandom), 1'b0);
    wait_ticks(6);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    drive_start(8'h5A, 1'b0);
    wait_idle();

    drive_start(8'hC3, 1'b1);
    wait_idle();

    for (int k = 0; k < 16; k++) begin
      drive_start(8'($urandom), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 1) == 1) begin
        wait_ticks($urandom_range(1, 9));
        start   = 1'b1;
        data_in = 8'($urandom);
        step();
        start   = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 20)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
